seg595_display_top: RTL and testbench

- Self-running six-digit decimal display driver for a common-anode 7-segment module behind two cascaded 74HC595 shift registers.
- An internal counter increments every 100 ms, from 0 to 999_999 with wrap.
- The value is converted to BCD with leading-zero blanking and multiplexed across six digits at 1 ms per digit.
- Each {segment, select} word is serialised to the 595 chain over a 4-phase serial interface.

---
 rtl/seg595_pkg.sv | 52 +++++
 rtl/seg595_display_top_hc595_serializer.sv | 70 +++++++
 rtl/seg595_display_top.sv | 94 +++++++++
 tb/tb_seg595_display_top.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg595_pkg.sv
// Shared constants and helpers for the six-digit 7-segment / 74HC595 display driver.
package seg595_pkg;

    // Common-anode, active-low segment codes with bit7 = decimal point (always off).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int BITS_PER_FRAME = 14;
    localparam int PHASES         = 4;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Shift-and-add-3 conversion of a 20-bit binary value into six BCD digits.
    function automatic logic [23:0] bin_to_bcd(input logic [19:0] bin);
        logic [43:0] sh;
        sh = {24'd0, bin};
        for (int i = 0; i < 20; i++) begin
            for (int d = 0; d < 6; d++) begin
                sh[20 + 4*d +: 4] = (sh[20 + 4*d +: 4] >= 4'd5) ? (sh[20 + 4*d +: 4] + 4'd3)
                                                                : sh[20 + 4*d +: 4];
            end
            sh = sh << 1;
        end
        return sh[43:20];
    endfunction

endpackage

// File: rtl/seg595_display_top_hc595_serializer.sv
// Serialises one {seg, sel} word per 56-clock frame into a two-stage 74HC595 chain.
module hc595_serializer
    import seg595_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg,
    input  logic [5:0] sel,
    output logic       shcp,
    output logic       stcp,
    output logic       ds
);

    localparam logic [3:0] LAST_BIT   = 4'(BITS_PER_FRAME - 1);
    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

    logic [1:0]  cnt_4_r;
    logic [3:0]  cnt_bit_r;
    logic [13:0] word_r;

    logic        frame_start_s;
    logic        last_slot_s;
    logic [13:0] word_s;
    logic [3:0]  bit_idx_s;
    logic        ds_next_s;

    // Frame position decode and selection of the bit to put on ds.
    always_comb begin
        frame_start_s = (cnt_bit_r == 4'd0) && (cnt_4_r == 2'd0);
        last_slot_s   = (cnt_bit_r == LAST_BIT) && (cnt_4_r == LAST_PHASE);
        // The first bit of a frame must come from the word being snapshotted on this edge.
        word_s        = frame_start_s ? {seg, sel} : word_r;
        if (cnt_bit_r < 4'd6) begin
            bit_idx_s = cnt_bit_r;
        end else begin
            bit_idx_s = 4'd13 - (cnt_bit_r - 4'd6);
        end
        ds_next_s = word_s[bit_idx_s];
    end

    // Phase/bit counters, word snapshot and the three 595 control pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_4_r   <= 2'd0;
            cnt_bit_r <= 4'd0;
            word_r    <= 14'd0;
            shcp      <= 1'b0;
            stcp      <= 1'b0;
            ds        <= 1'b0;
        end else begin
            cnt_4_r <= (cnt_4_r == LAST_PHASE) ? 2'd0 : (cnt_4_r + 2'd1);
            if (cnt_4_r == LAST_PHASE) begin
                cnt_bit_r <= (cnt_bit_r == LAST_BIT) ? 4'd0 : (cnt_bit_r + 4'd1);
            end
            if (frame_start_s) begin
                word_r <= {seg, sel};
            end
            case (cnt_4_r)
                2'd0: begin
                    ds   <= ds_next_s;
                    shcp <= 1'b0;
                end
                2'd2:    shcp <= 1'b1;
                default: shcp <= shcp;
            endcase
            stcp <= last_slot_s;
        end
    end

endmodule

// File: rtl/seg595_display_top.sv
// Self-running 0..999_999 counter shown on six multiplexed common-anode digits via 74HC595s.
module seg595_display_top
    import seg595_pkg::*;
#(
    parameter logic [22:0] CNT_100MS_MAX = 23'd4_999_999,
    parameter logic [15:0] CNT_1MS_MAX   = 16'd49_999,
    parameter logic [19:0] DATA_MAX      = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic shcp,
    output logic stcp,
    output logic ds,
    output logic oe
);

    logic [22:0] cnt_100ms_r;
    logic [19:0] value_r;
    logic [23:0] bcd_r;
    logic [15:0] cnt_1ms_r;
    logic [2:0]  digit_idx_r;
    logic [5:0]  sel_r;
    logic [7:0]  seg_r;

    logic        tick_s;
    logic        scan_tick_s;
    logic [5:0]  blank_s;
    logic [3:0]  digit_s;
    logic        digit_blank_s;
    logic [7:0]  seg_next_s;

    assign oe = sys_rst;

    // Leading-zero blanking and segment code for the digit currently scanned.
    always_comb begin : display_logic
        logic zero_above;
        tick_s      = (cnt_100ms_r == CNT_100MS_MAX);
        scan_tick_s = (cnt_1ms_r == CNT_1MS_MAX);
        zero_above  = 1'b1;
        blank_s     = 6'b000000;
        for (int k = 5; k >= 1; k--) begin
            zero_above = zero_above && (bcd_r[4*k +: 4] == 4'd0);
            blank_s[k] = zero_above;
        end
        case (digit_idx_r)
            3'd0:    digit_s = bcd_r[3:0];
            3'd1:    digit_s = bcd_r[7:4];
            3'd2:    digit_s = bcd_r[11:8];
            3'd3:    digit_s = bcd_r[15:12];
            3'd4:    digit_s = bcd_r[19:16];
            3'd5:    digit_s = bcd_r[23:20];
            default: digit_s = 4'hF;
        endcase
        digit_blank_s = (digit_idx_r <= 3'd5) ? blank_s[digit_idx_r] : 1'b1;
        seg_next_s    = digit_blank_s ? SEG_BLANK : seg_encode(digit_s);
    end

    // Value generator, BCD pipeline stage and digit scanner.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_100ms_r <= 23'd0;
            value_r     <= 20'd0;
            bcd_r       <= 24'd0;
            cnt_1ms_r   <= 16'd0;
            digit_idx_r <= 3'd0;
            sel_r       <= 6'b000001;
            seg_r       <= SEG_0;
        end else begin
            cnt_100ms_r <= tick_s ? 23'd0 : (cnt_100ms_r + 23'd1);
            if (tick_s) begin
                value_r <= (value_r == DATA_MAX) ? 20'd0 : (value_r + 20'd1);
            end
            bcd_r     <= bin_to_bcd(value_r);
            cnt_1ms_r <= scan_tick_s ? 16'd0 : (cnt_1ms_r + 16'd1);
            if (scan_tick_s) begin
                digit_idx_r <= (digit_idx_r >= 3'd5) ? 3'd0 : (digit_idx_r + 3'd1);
            end
            // sel and seg are loaded on the same edge so a digit never shows its neighbour's code.
            sel_r <= 6'b000001 << digit_idx_r;
            seg_r <= seg_next_s;
        end
    end

    hc595_serializer u_serializer (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .seg  (seg_r),
        .sel  (sel_r),
        .shcp (shcp),
        .stcp (stcp),
        .ds   (ds)
    );

endmodule

// File: tb/tb_seg595_display_top.sv
// Directed bench: decodes every 595 frame and checks it against a tick-counting display model.
module tb_seg595_display_top;

    localparam int TICK  = 50;
    localparam int FRAME = 56;
    localparam int DMAX  = 999_999;
    localparam int HMAX  = 2047;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic shcp, stcp, ds, oe;

    int checks = 0;
    int errors = 0;
    int k = 0;
    bit active = 1'b0;
    bit force_hit = 1'b0;
    int m_value = 0;
    int hist [0:HMAX];
    logic [13:0] fbits = 14'd0;
    logic prev_ds = 1'b0;
    logic prev_shcp = 1'b0;
    int rises = 0;
    int last_stcp = -1;
    logic [7:0] enc [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg595_display_top #(
        .CNT_100MS_MAX (23'd49),
        .CNT_1MS_MAX   (16'd19),
        .DATA_MAX      (20'd999_999)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .shcp    (shcp),
        .stcp    (stcp),
        .ds      (ds),
        .oe      (oe)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int v, input int i);
        int p = 1;
        for (int n = 0; n < i; n++) p = p * 10;
        if (i > 0 && v < p) return 8'hFF;
        return enc[(v / p) % 10];
    endfunction

    task automatic check_frame(input int j_in);
        logic [5:0] sel;
        logic [7:0] seg;
        logic [7:0] lit;
        int j, i, want;
        bit ok;
        j = (j_in < 0) ? 0 : ((j_in > HMAX) ? HMAX : j_in);
        sel = fbits[5:0];
        seg = {fbits[6], fbits[7], fbits[8], fbits[9], fbits[10], fbits[11], fbits[12], fbits[13]};
        i = -1;
        for (int n = 0; n < 6; n++) if (sel == (6'b000001 << n)) i = n;
        if (i < 0) begin
            check("frame_sel_onehot", 1'b0, int'(sel), 1);
        end else begin
            // The displayed value may lag the tick by the pipeline; accept the last three model values.
            ok = 1'b0;
            for (int d = 0; d <= 2; d++)
                if (j - d >= 0 && exp_seg(hist[j - d], i) == seg) ok = 1'b1;
            want = int'(exp_seg(hist[(j >= 2) ? j - 2 : 0], i));
            check("frame_seg", ok, int'(seg), want);
        end
        if (j == 0)
            check("first_frame", (sel == 6'b000001) && (seg == 8'hC0), int'({sel, seg}), int'({6'b000001, 8'hC0}));
        if (j >= 605 && j <= 645) begin
            case (sel)
                6'b000001: lit = 8'hA4;
                6'b000010: lit = 8'hF9;
                default:   lit = 8'hFF;
            endcase
            check("value12_frame", seg == lit, int'(seg), int'(lit));
        end
        if (j >= 755 && j <= 795) begin
            lit = (sel == 6'b000001) ? 8'hC0 : 8'hFF;
            check("wrap_frame", seg == lit, int'(seg), int'(lit));
        end
    endtask

    // Single compare process: advances the model each cycle and checks the pins at the falling edge.
    always @(negedge sys_clk) begin
        if (!active) begin
            k = 0;
            m_value = 0;
            hist[0] = 0;
            prev_ds = 1'b0;
            prev_shcp = 1'b0;
            rises = 0;
            last_stcp = -1;
        end else begin
            k++;
            if (k % TICK == 0) m_value = (m_value == DMAX) ? 0 : m_value + 1;
            if (force_hit) begin
                m_value = DMAX;
                force_hit = 1'b0;
            end
            if (k <= HMAX) hist[k] = m_value;
            check("shcp", shcp == ((k >= 3) && (k % 4 == 3 || k % 4 == 0)), int'(shcp),
                  int'((k >= 3) && (k % 4 == 3 || k % 4 == 0)));
            check("stcp", stcp == (k % FRAME == 0), int'(stcp), int'(k % FRAME == 0));
            if (k % 4 != 1) check("ds_stable", ds == prev_ds, int'(ds), int'(prev_ds));
            if (shcp && !prev_shcp) begin
                rises++;
                fbits[4'((k % FRAME) / 4)] = ds;
            end
            if (stcp) begin
                if (last_stcp >= 0) check("stcp_period", (k - last_stcp) == FRAME, k - last_stcp, FRAME);
                check("shcp_per_frame", rises == 14, rises, 14);
                rises = 0;
                last_stcp = k;
                check_frame(k - FRAME);
            end
            prev_ds = ds;
            prev_shcp = shcp;
        end
    end

    // Advance to 2 ns after the n-th rising edge since reset release.
    task automatic run_to(input int n);
        int guard = 0;
        @(posedge sys_clk);
        #2;
        while (k + 1 < n && guard < 5000) begin
            @(posedge sys_clk);
            #2;
            guard++;
        end
        if (k + 1 != n) check("run_to_timeout", 1'b0, k + 1, n);
    endtask

    initial begin
        #15;
        check("rst_shcp", shcp == 1'b0, int'(shcp), 0);
        check("rst_stcp", stcp == 1'b0, int'(stcp), 0);
        check("rst_ds", ds == 1'b0, int'(ds), 0);
        check("rst_oe", oe == 1'b1, int'(oe), 1);
        #7;
        sys_rst = 1'b0;
        active = 1'b1;
        #3;
        check("run_oe", oe == 1'b0, int'(oe), 0);

        run_to(600);
        check("value_12", dut.value_r == 20'd12, int'(dut.value_r), 12);

        run_to(700);
        force dut.value_r = 20'd999_999;
        force_hit = 1'b1;
        run_to(701);
        release dut.value_r;
        run_to(749);
        check("value_max", dut.value_r == 20'd999_999, int'(dut.value_r), DMAX);
        run_to(750);
        check("value_wrap", dut.value_r == 20'd0, int'(dut.value_r), 0);

        // 871 mod 56 = 31: bit 7, phase 3, shcp high.
        run_to(871);
        sys_rst = 1'b1;
        active = 1'b0;
        #1;
        check("mid_rst_shcp", shcp == 1'b0, int'(shcp), 0);
        check("mid_rst_stcp", stcp == 1'b0, int'(stcp), 0);
        check("mid_rst_ds", ds == 1'b0, int'(ds), 0);
        check("mid_rst_oe", oe == 1'b1, int'(oe), 1);
        @(posedge sys_clk);
        #12;
        sys_rst = 1'b0;
        active = 1'b1;
        run_to(3 * FRAME + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
